mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, fixed-latency doubleword memory between the fetch unit (read-only)
//  and the load/store unit (read or write) of the multi-cycle PPC core.
//  Serialises requests, picks a winner, issues one memory command and steers the response back.
//  Data side has priority; a streak limit guarantees fetch forward progress.
// PARAMETERS
//  ADDR_W           61  doubleword address width (byte address bits [0:60])
//  DATA_W           64  memory word width
//  MEM_LAT          1   cycles from m_en to valid m_rdata (>=1)
//  MAX_DATA_STREAK  4   consecutive data grants allowed while if_req pends (>=1)
// PORTS
//  clk        in   1       core clock, all state on posedge
//  rst        in   1       asynchronous, active-high reset
//  if_req     in   1       fetch read request; hold with if_addr stable until if_gnt
//  if_addr    in   ADDR_W  fetch doubleword address
//  if_gnt     out  1       fetch command issued this cycle
//  if_rvalid  out  1       one-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  fetch read data
//  d_req      in   1       data request; hold d_we/d_addr/d_wdata stable until d_gnt
//  d_we       in   1       1 = write (std), 0 = read (ld/ldu)
//  d_addr     in   ADDR_W  data doubleword address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       data command issued this cycle
//  d_rvalid   out  1       one-cycle pulse: data op complete, d_rdata valid for reads
//  d_rdata    out  DATA_W  load data (0 for writes)
//  m_en       out  1       memory command strobe
//  m_we       out  1       memory write enable (qualified by m_en)
//  m_addr     out  ADDR_W  memory address
//  m_wdata    out  DATA_W  memory write data
//  m_rdata    in   DATA_W  memory read data, valid MEM_LAT cycles after m_en
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, streak counter 0, latency counter 0, rdata regs 0.
//  - FSM IDLE -> WAIT -> RESP -> IDLE; one transaction in flight, no queuing.
//  - IDLE (cycle T): if any req, pick winner; combinationally assert m_en, winner's gnt,
//    and drive m_we/m_addr/m_wdata from winner (fetch: m_we=0, m_wdata=0). Go to WAIT.
//    With no req: m_en=0, m_addr/m_wdata/m_we=0.
//  - WAIT: count MEM_LAT cycles (T+1..T+MEM_LAT); on the last, register m_rdata (0 if write)
//    into the winner's rdata reg. Go to RESP.
//  - RESP (T+MEM_LAT+1): winner's rvalid=1 (registered). Go to IDLE; next issue at T+MEM_LAT+2 at the earliest.
//  - Pick: data wins when both req, unless streak==MAX_DATA_STREAK and if_req=1 -> fetch wins.
//  - Streak: +1 on each d_gnt while if_req=1 (saturate at MAX); cleared on if_gnt or whenever if_req=0 in IDLE.
//  - gnt never asserts outside IDLE; never both gnts in one cycle; rvalid never to non-winner.
//  - if_rdata/d_rdata hold last value until overwritten; only rvalid qualifies them.
//  - Request withdrawn before gnt: no command issued. Req held after gnt = new request.
//  - Write completes at issue in memory; d_rvalid still pulses at T+MEM_LAT+1 (store ack).
//  - rst mid-transaction: immediate return to IDLE, rvalid/gnt drop, pending response discarded;
//    a write already issued may have landed in memory.
// STRUCTURE
//  - Package ppc_mem_pkg: ADDR_W/DATA_W defaults, FSM state encodings (IDLE/WAIT/RESP),
//    requester ID encoding (REQ_IF=0, REQ_D=1).
//  - One sub-module mem_arb_pick: combinational winner select from if_req, d_req, streak==MAX.
//  - Top holds FSM, latency counter ($clog2(MAX(MEM_LAT,2)) bits), streak counter, winner-ID reg, rdata regs.
// TESTING
//  1. if_req only, if_addr=0x10, m_rdata=0xDEAD at T+1 (MEM_LAT=1) -> if_gnt@T, if_rvalid@T+2, if_rdata=0xDEAD.
//  2. d_req write, d_addr=0x20, d_wdata=0x1234 -> m_en=m_we=1, m_addr=0x20 @T; d_rvalid@T+2, d_rdata=0.
//  3. Both req held continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,IF, then repeats.
//  4. MEM_LAT=3, single read -> gnt@T, rvalid@T+4, next gnt no earlier than T+5.
//  5. rst asserted in WAIT -> all outputs 0 that cycle, no rvalid afterwards; fresh req after release served normally.
//  6. d_req dropped before IDLE with if_req low -> m_en stays 0, no gnt, streak stays 0.

Source files
------------

// File: rtl/ppc_mem_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package ppc_mem_pkg;

  localparam int ADDR_W_DFLT = 61;
  localparam int DATA_W_DFLT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  // Latency counter width: wide enough to count MEM_LAT wait cycles, never zero bits.
  function automatic int lat_cnt_w(int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if
  import ppc_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data side wins unless fetch has waited out a full streak.
module mem_arb_pick
  import ppc_mem_pkg::*;
(
  input  logic    if_req_i,
  input  logic    d_req_i,
  input  logic    streak_max_i,
  output logic    valid_o,
  output req_id_e winner_o
);

  always_comb begin
    valid_o = if_req_i | d_req_i;
    if (d_req_i && !(if_req_i && streak_max_i)) begin
      winner_o = REQ_D;
    end else begin
      winner_o = REQ_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch and load/store, one transaction in flight,
// data side favoured but bounded by a streak limit so fetch always progresses.
module mem_port_arbiter
  import ppc_mem_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DFLT,
  parameter int DATA_W          = DATA_W_DFLT,
  parameter int MEM_LAT         = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = lat_cnt_w(MEM_LAT);
  localparam int STK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DATA_STREAK);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  req_id_e           winner_q, winner_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              pick_valid;
  req_id_e           pick_id;
  logic              issue;
  logic [ADDR_W-1:0] pick_addr;

  mem_arb_pick u_pick (
    .if_req_i     (bus.if_req),
    .d_req_i      (bus.d_req),
    .streak_max_i (streak_q == STK_MAX),
    .valid_o      (pick_valid),
    .winner_o     (pick_id)
  );

  // Gated by rst so nothing is issued while reset is held, even from IDLE.
  assign issue = (state_q == ST_IDLE) && pick_valid && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= '0;
      streak_q   <= '0;
      winner_q   <= REQ_IF;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      streak_q   <= streak_d;
      winner_q   <= winner_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    streak_d   = streak_q;
    winner_d   = winner_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.if_req) begin
          streak_d = '0;
        end
        if (issue) begin
          state_d   = ST_WAIT;
          lat_cnt_d = '0;
          winner_d  = pick_id;
          we_d      = (pick_id == REQ_D) && bus.d_we;
          if (pick_id == REQ_IF) begin
            streak_d = '0;
          end else if (bus.if_req && (streak_q != STK_MAX)) begin
            streak_d = streak_q + STK_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = ST_RESP;
          if (winner_q == REQ_IF) begin
            if_rdata_d = bus.m_rdata;
          end else begin
            d_rdata_d = we_q ? '0 : bus.m_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pick_addr     = (pick_id == REQ_D) ? bus.d_addr : bus.if_addr;
    bus.if_gnt    = issue && (pick_id == REQ_IF);
    bus.d_gnt     = issue && (pick_id == REQ_D);
    bus.m_en      = issue;
    bus.m_we      = issue && (pick_id == REQ_D) && bus.d_we;
    bus.m_addr    = issue ? pick_addr : '0;
    bus.m_wdata   = (issue && (pick_id == REQ_D)) ? bus.d_wdata : '0;
    bus.if_rvalid = (state_q == ST_RESP) && (winner_q == REQ_IF);
    bus.d_rvalid  = (state_q == ST_RESP) && (winner_q == REQ_D);
    bus.if_rdata  = if_rdata_q;
    bus.d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter at MEM_LAT=1 and MEM_LAT=3.
module tb_mem_port_arbiter;
  import ppc_mem_pkg::*;

  localparam int AW   = 61;
  localparam int DW   = 64;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit             sel;
  logic           if_req, d_req, d_we;
  logic [AW-1:0]  if_addr, d_addr;
  logic [DW-1:0]  d_wdata;
  int             checks = 0;
  int             errors = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_DATA_STREAK(MAXS)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .MAX_DATA_STREAK(MAXS)) dut3 (
    .clk (clk), .rst (rst), .bus (bus3));

  // The unselected arbiter sees no requests, so it stays idle.
  assign bus1.if_req  = if_req & ~sel;
  assign bus1.d_req   = d_req & ~sel;
  assign bus3.if_req  = if_req & sel;
  assign bus3.d_req   = d_req & sel;
  assign bus1.if_addr = if_addr;
  assign bus3.if_addr = if_addr;
  assign bus1.d_addr  = d_addr;
  assign bus3.d_addr  = d_addr;
  assign bus1.d_we    = d_we;
  assign bus3.d_we    = d_we;
  assign bus1.d_wdata = d_wdata;
  assign bus3.d_wdata = d_wdata;

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 16) return 64'hDEAD;
    return {32'hA5A5_0000 + 32'(i), 32'(i) * 32'h9E37_79B9};
  endfunction

  // Memory environment: fixed-latency read pipes, garbage when no read is pending.
  logic [DW-1:0] mem1 [64];
  logic [DW-1:0] mem3 [64];
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [3];

  always @(posedge clk) begin
    for (int i = 0; i < 64; i++) if (rst) mem1[i] <= init_val(i);
    if (!rst && bus1.m_en && bus1.m_we) mem1[bus1.m_addr[5:0]] <= bus1.m_wdata;
    pipe1 <= (bus1.m_en && !bus1.m_we) ? mem1[bus1.m_addr[5:0]] : {$urandom, $urandom};
  end

  always @(posedge clk) begin
    for (int i = 0; i < 64; i++) if (rst) mem3[i] <= init_val(i);
    if (!rst && bus3.m_en && bus3.m_we) mem3[bus3.m_addr[5:0]] <= bus3.m_wdata;
    pipe3[0] <= (bus3.m_en && !bus3.m_we) ? mem3[bus3.m_addr[5:0]] : {$urandom, $urandom};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign bus1.m_rdata = pipe1;
  assign bus3.m_rdata = pipe3[2];

  logic          o_if_gnt, o_d_gnt, o_m_en, o_m_we, o_if_rvalid, o_d_rvalid;
  logic [AW-1:0] o_m_addr;
  logic [DW-1:0] o_m_wdata, o_if_rdata, o_d_rdata;
  assign o_if_gnt    = sel ? bus3.if_gnt    : bus1.if_gnt;
  assign o_d_gnt     = sel ? bus3.d_gnt     : bus1.d_gnt;
  assign o_m_en      = sel ? bus3.m_en      : bus1.m_en;
  assign o_m_we      = sel ? bus3.m_we      : bus1.m_we;
  assign o_if_rvalid = sel ? bus3.if_rvalid : bus1.if_rvalid;
  assign o_d_rvalid  = sel ? bus3.d_rvalid  : bus1.d_rvalid;
  assign o_m_addr    = sel ? bus3.m_addr    : bus1.m_addr;
  assign o_m_wdata   = sel ? bus3.m_wdata   : bus1.m_wdata;
  assign o_if_rdata  = sel ? bus3.if_rdata  : bus1.if_rdata;
  assign o_d_rdata   = sel ? bus3.d_rdata   : bus1.d_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 61'h10; d_addr = 61'h20; d_wdata = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_if_gnt, o_d_gnt, o_m_en, o_m_we, o_if_rvalid, o_d_rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {o_if_gnt, o_d_gnt, o_m_en, o_m_we, o_if_rvalid, o_d_rvalid});
    end
    checks++;
    if (o_m_addr !== '0 || o_m_wdata !== '0) begin
      errors++;
      $display("FAIL reset_bus: got addr %h wdata %h expected 0", o_m_addr, o_m_wdata);
    end
    checks++;
    if (o_if_rdata !== '0 || o_d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h expected 0", o_if_rdata, o_d_rdata);
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fetch_read();
    sel = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 61'h10;
    @(negedge clk);
    checks++;
    if ({o_if_gnt, o_d_gnt, o_m_en, o_m_we} !== 4'b1010) begin
      errors++;
      $display("FAIL fetch_issue: got %b expected 1010", {o_if_gnt, o_d_gnt, o_m_en, o_m_we});
    end
    checks++;
    if (o_m_addr !== 61'h10 || o_m_wdata !== '0) begin
      errors++;
      $display("FAIL fetch_bus: got addr %h wdata %h expected 10/0", o_m_addr, o_m_wdata);
    end
    tick();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_if_gnt, o_m_en, o_if_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL fetch_wait: got %b expected 000", {o_if_gnt, o_m_en, o_if_rvalid});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({o_if_rvalid, o_d_rvalid} !== 2'b10 || o_if_rdata !== 64'hDEAD) begin
      errors++;
      $display("FAIL fetch_resp: got rv %b data %h expected 10/dead",
               {o_if_rvalid, o_d_rvalid}, o_if_rdata);
    end
    $display("txn fetch addr 10 data %h", o_if_rdata);
    tick();
    @(negedge clk);
    checks++;
    if (o_if_rvalid !== 1'b0 || o_if_rdata !== 64'hDEAD) begin
      errors++;
      $display("FAIL fetch_hold: got rv %b data %h expected 0/dead", o_if_rvalid, o_if_rdata);
    end
  endtask

  task automatic test_data_write();
    sel = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 61'h20; d_wdata = 64'h1234;
    @(negedge clk);
    checks++;
    if ({o_if_gnt, o_d_gnt, o_m_en, o_m_we} !== 4'b0111 || o_m_addr !== 61'h20
        || o_m_wdata !== 64'h1234) begin
      errors++;
      $display("FAIL write_issue: got %b addr %h wdata %h expected 0111/20/1234",
               {o_if_gnt, o_d_gnt, o_m_en, o_m_we}, o_m_addr, o_m_wdata);
    end
    tick();
    d_req = 1'b0; d_we = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({o_if_rvalid, o_d_rvalid} !== 2'b01 || o_d_rdata !== '0 || o_if_rdata !== 64'hDEAD) begin
      errors++;
      $display("FAIL write_ack: got rv %b d %h if %h expected 01/0/dead",
               {o_if_rvalid, o_d_rvalid}, o_d_rdata, o_if_rdata);
    end
    $display("txn store addr 20 ack");
    tick();
  endtask

  task automatic test_streak();
    int n;
    int last;
    bit exp_if;
    sel = 1'b0;
    do_reset();
    tick();
    if_req = 1'b1; if_addr = 61'h3; d_req = 1'b1; d_we = 1'b0; d_addr = 61'h4;
    n = 0; last = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(negedge clk);
      checks++;
      if (o_if_gnt && o_d_gnt) begin
        errors++;
        $display("FAIL streak_both: got both gnts expected one at cycle %0d", c);
      end
      if (o_if_gnt || o_d_gnt) begin
        exp_if = (n % 5) == 4;
        checks++;
        if (o_if_gnt !== exp_if) begin
          errors++;
          $display("FAIL streak_order: grant %0d got if_gnt %b expected %b", n, o_if_gnt, exp_if);
        end
        if (n > 0) begin
          checks++;
          if (c - last != 3) begin
            errors++;
            $display("FAIL streak_gap: got %0d cycles expected 3", c - last);
          end
        end
        $display("txn streak grant %0d to %s", n, o_if_gnt ? "fetch" : "data");
        last = c;
        n++;
      end
      tick();
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL streak_count: got %0d grants expected 10", n);
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_latency3();
    bit e_gnt;
    bit e_rv;
    sel = 1'b1;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 61'h5;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      e_gnt = (k == 0) || (k == 5);
      e_rv  = (k == 4);
      checks++;
      if ({o_d_gnt, o_d_rvalid, o_if_gnt, o_if_rvalid} !== {e_gnt, e_rv, 2'b00}) begin
        errors++;
        $display("FAIL lat3_timing: k=%0d got %b expected %b", k,
                 {o_d_gnt, o_d_rvalid, o_if_gnt, o_if_rvalid}, {e_gnt, e_rv, 2'b00});
      end
      if (k == 4) begin
        checks++;
        if (o_d_rdata !== init_val(5)) begin
          errors++;
          $display("FAIL lat3_data: got %h expected %h", o_d_rdata, init_val(5));
        end
        $display("txn lat3 load addr 5 data %h", o_d_rdata);
      end
      tick();
    end
    d_req = 1'b0;
    repeat (6) tick();
    sel = 1'b0;
  endtask

  task automatic test_rst_mid();
    sel = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 61'h7;
    @(negedge clk);
    checks++;
    if (o_if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_gnt: got %b expected 1", o_if_gnt);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_if_gnt, o_d_gnt, o_m_en, o_m_we, o_if_rvalid, o_d_rvalid} !== 6'b0
        || o_m_addr !== '0 || o_if_rdata !== '0) begin
      errors++;
      $display("FAIL rstmid_out: got %b addr %h rdata %h expected all 0",
               {o_if_gnt, o_d_gnt, o_m_en, o_m_we, o_if_rvalid, o_d_rvalid}, o_m_addr, o_if_rdata);
    end
    tick();
    if_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid} !== 4'b0) begin
        errors++;
        $display("FAIL rstmid_quiet: k=%0d got %b expected 0000", k,
                 {o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid});
      end
      tick();
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 61'h9;
    @(negedge clk);
    checks++;
    if (o_d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_fresh_gnt: got %b expected 1", o_d_gnt);
    end
    tick();
    d_req = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (o_d_rvalid !== 1'b1 || o_d_rdata !== init_val(9)) begin
      errors++;
      $display("FAIL rstmid_fresh_resp: got %b/%h expected 1/%h", o_d_rvalid, o_d_rdata, init_val(9));
    end
    $display("txn load after reset addr 9 data %h", o_d_rdata);
    tick();
  endtask

  task automatic test_withdraw();
    sel = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 61'h3;
    @(negedge clk);
    checks++;
    if (o_if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL withdraw_fetch_gnt: got %b expected 1", o_if_gnt);
    end
    tick();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 61'h30; d_wdata = 64'h55;
    @(negedge clk);
    checks++;
    if ({o_d_gnt, o_m_en} !== 2'b00) begin
      errors++;
      $display("FAIL withdraw_busy: got %b expected 00", {o_d_gnt, o_m_en});
    end
    tick();
    d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({o_d_gnt, o_m_en, o_m_we} !== 3'b000) begin
        errors++;
        $display("FAIL withdraw_idle: k=%0d got %b expected 000", k, {o_d_gnt, o_m_en, o_m_we});
      end
      tick();
    end
    checks++;
    if (dut1.streak_q !== '0) begin
      errors++;
      $display("FAIL withdraw_streak: got %0d expected 0", dut1.streak_q);
    end
  endtask

  // Randomized traffic against a cycle-level transaction model of the arbitration rules.
  task automatic test_random(bit s, int ncyc);
    int lat_m, next_ok, streak, rsp_cyc;
    bit rsp_pend, rsp_d, g_if, g_d, idle, issue, dwin;
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] rsp_data, e_ifr, e_dr, e_wdata;
    logic [AW-1:0] e_addr;
    logic [5:0] e_ctl;
    sel = s;
    lat_m = s ? 3 : 1;
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    next_ok = 0; streak = 0; rsp_cyc = 0; rsp_pend = 1'b0; rsp_d = 1'b0;
    rsp_data = '0; e_ifr = '0; e_dr = '0; g_if = 1'b0; g_d = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      tick();
      if (if_req && g_if) begin
        if ($urandom_range(3) == 0) if_addr = AW'({$urandom, $urandom});
        else if_req = 1'b0;
      end else if (if_req) begin
        if ($urandom_range(15) == 0) if_req = 1'b0;
      end else if ($urandom_range(3) != 0) begin
        if_req = 1'b1; if_addr = AW'({$urandom, $urandom});
      end
      if (d_req && !g_d) begin
        if ($urandom_range(15) == 0) d_req = 1'b0;
      end else if ((d_req && g_d && $urandom_range(3) == 0) || (!d_req && $urandom_range(3) != 0)) begin
        d_req = 1'b1; d_we = 1'($urandom_range(1));
        d_addr = AW'({$urandom, $urandom}); d_wdata = {$urandom, $urandom};
      end else begin
        d_req = 1'b0;
      end
      @(negedge clk);
      idle  = cyc >= next_ok;
      issue = idle && (if_req || d_req);
      dwin  = d_req && !(if_req && streak == MAXS);
      e_addr  = !issue ? '0 : (dwin ? d_addr : if_addr);
      e_wdata = (issue && dwin) ? d_wdata : '0;
      e_ctl = {issue && !dwin, issue && dwin, issue, issue && dwin && d_we,
               rsp_pend && cyc == rsp_cyc && !rsp_d, rsp_pend && cyc == rsp_cyc && rsp_d};
      if (rsp_pend && cyc == rsp_cyc) begin
        if (rsp_d) e_dr = rsp_data; else e_ifr = rsp_data;
        rsp_pend = 1'b0;
        $display("txn lat%0d %s data %h", lat_m, rsp_d ? "data" : "fetch", rsp_data);
      end
      checks++;
      if ({o_if_gnt, o_d_gnt, o_m_en, o_m_we, o_if_rvalid, o_d_rvalid} !== e_ctl) begin
        errors++;
        $display("FAIL rand_ctl: lat%0d cyc %0d got %b expected %b", lat_m, cyc,
                 {o_if_gnt, o_d_gnt, o_m_en, o_m_we, o_if_rvalid, o_d_rvalid}, e_ctl);
      end
      checks++;
      if (o_m_addr !== e_addr || o_m_wdata !== e_wdata) begin
        errors++;
        $display("FAIL rand_bus: lat%0d cyc %0d got %h/%h expected %h/%h", lat_m, cyc,
                 o_m_addr, o_m_wdata, e_addr, e_wdata);
      end
      checks++;
      if (o_if_rdata !== e_ifr || o_d_rdata !== e_dr) begin
        errors++;
        $display("FAIL rand_rdata: lat%0d cyc %0d got %h/%h expected %h/%h", lat_m, cyc,
                 o_if_rdata, o_d_rdata, e_ifr, e_dr);
      end
      g_if = o_if_gnt;
      g_d  = o_d_gnt;
      if (idle && !if_req) streak = 0;
      if (issue) begin
        if (!dwin) streak = 0;
        else if (if_req && streak < MAXS) streak++;
        rsp_pend = 1'b1; rsp_d = dwin;
        rsp_cyc = cyc + lat_m + 1; next_ok = cyc + lat_m + 2;
        if (dwin && d_we) begin
          ref_mem[e_addr[5:0]] = d_wdata;
          rsp_data = '0;
        end else begin
          rsp_data = ref_mem[e_addr[5:0]];
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_streak();
    test_latency3();
    test_rst_mid();
    test_withdraw();
    test_random(1'b0, 400);
    test_random(1'b1, 400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
